// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Provides the FSM state encoding and the iteration-counter width function.
// Optional feature macro used by the divider: DIV_ZERO_FLAG_EN.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter must hold WIDTH-1; never let it collapse to zero bits.
    function automatic int count_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left and trial-subtract B.
// Purely combinational; zero latency.
// No handshake of its own; the caller decides when to register the result.
module div_step #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   b_ext;

    assign shifted = {rem_i, quo_i} << 1;
    assign rem_sh  = shifted[2*WIDTH:WIDTH];
    assign b_ext   = {1'b0, b_i};

    // Keep the shifted remainder unless the divisor fits, then subtract and set the quotient bit.
    always_comb begin
        rem_o = rem_sh;
        quo_o = shifted[WIDTH-1:0];
        if (rem_sh >= b_ext) begin
            rem_o    = rem_sh - b_ext;
            quo_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing Q=A/B and R=A%B, one quotient bit per clock.
// Latency: accept edge plus WIDTH CALC edges (1 edge for B==0 when DIV_ZERO_FLAG_EN is defined).
// Backpressure: result and flags hold while out_valid_o && !out_ready_i; no new accept until IDLE.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             busy_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero_o
`endif
);

    localparam int CW = count_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .b_i   (b_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic: accept operands in IDLE, iterate in CALC, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
`ifdef DIV_ZERO_FLAG_EN
                    if (b_i == '0) begin
                        // Divide by zero short-circuits to the same values the iteration would give.
                        q_d     = '1;
                        r_d     = a_i;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        b_d     = b_i;
                        quo_d   = a_i;
                        rem_d   = '0;
                        count_d = CW'(WIDTH - 1);
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
`else
                    b_d     = b_i;
                    quo_d   = a_i;
                    rem_d   = '0;
                    count_d = CW'(WIDTH - 1);
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    q_d     = step_quo;
                    r_d     = step_rem[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == CALC) || (state_q == DONE);
    assign q_o         = q_q;
    assign r_o         = r_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero_o  = dz_q;
`else
    // Without the flag the latched zero-divide bit is never set; keep it tied off.
    logic unused_dz;
    assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=3: directed corner cases plus random operations.
// Expected Q/R come from integer division; latency and handshake expectations are fixed numbers.
// Build with DIV_ZERO_FLAG_EN defined to also check the zero-divide flag and its short path.
module tb_seq_divider;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
`ifdef DIV_ZERO_FLAG_EN
    logic         dz;
`endif

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .q_o         (q),
        .r_o         (r),
        .busy_o      (busy)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o  (dz)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: plain integer division; divide-by-zero gives all ones and the dividend.
    function automatic int ref_q(input int x, input int y);
        return (y == 0) ? ((1 << W) - 1) : x / y;
    endfunction

    function automatic int ref_r(input int x, input int y);
        return (y == 0) ? x : x % y;
    endfunction

    function automatic int ref_lat(input int y);
`ifdef DIV_ZERO_FLAG_EN
        if (y == 0) return 1;
`endif
        return W + 1;
    endfunction

    // One full operation, entered and left at a negedge.
    // hold: cycles of out_ready low after the result appears; keep: leave in_valid high afterwards.
    task automatic run_op(input int x, input int y, input int hold, input bit keep);
        int edges;
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        a = W'(x);
        b = W'(y);
        in_valid = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_before_accept", int'(in_ready), 1);
        step();
        edges = 1;
        if (!keep) in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!out_valid && edges < 20) begin
            check("busy_during_calc", int'(busy), 1);
            step();
            edges++;
            a = W'($urandom);
            b = W'($urandom);
        end
        check("latency_edges", edges, ref_lat(y));
        check("q", int'(q), ref_q(x, y));
        check("r", int'(r), ref_r(x, y));
        check("in_ready_in_done", int'(in_ready), 0);
`ifdef DIV_ZERO_FLAG_EN
        check("div_zero", int'(dz), (y == 0) ? 1 : 0);
`endif
        q0 = q;
        r0 = r;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", int'(out_valid), 1);
            check("hold_q", int'(q), int'(q0));
            check("hold_r", int'(r), int'(r0));
        end
        out_ready = 1'b1;
        step();
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_keeps_q", int'(q), ref_q(x, y));
    endtask

    initial begin
        step();
        step();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_dz", int'(dz), 0);
`endif
        rst = 1'b0;
        step();

        // Directed corners.
        run_op(7, 2, 0, 1'b0);
        run_op(3, 5, 0, 1'b0);
        run_op(6, 6, 0, 1'b0);
        run_op(5, 0, 0, 1'b0);
        run_op(6, 4, 5, 1'b0);
        run_op(0, 3, 0, 1'b0);
        run_op(7, 1, 0, 1'b0);

        // Reset on the second CALC edge of 7/3 aborts the operation.
        a = 3'd7;
        b = 3'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_result", int'(out_valid), 0);
        end
        run_op(4, 2, 0, 1'b0);

        // Back-to-back with operands scrambled during CALC/DONE.
        run_op(5, 3, 0, 1'b1);
        run_op(7, 7, 1, 1'b1);
        run_op(2, 0, 0, 1'b1);
        run_op(6, 5, 0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
